// File: rtl/counter_seq_ctrl.sv
// Run-control sequencer for the tick-driven display counter.
// Build option: COUNTER_SEQ_AUTO_RELOAD_EN makes DONE a one-cycle pulse with automatic restart.
module counter_seq_ctrl #(
    parameter int PRESCALE = 50_000_000,
    parameter int PW       = 26,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          load_req,
    input  logic [CW-1:0] load_val,
    input  logic [CW-1:0] target,
    input  logic [CW-1:0] count,
    output logic          tick,
    output logic          clr,
    output logic          set,
    output logic [CW-1:0] init,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    localparam logic [PW-1:0] RELOAD = PW'(PRESCALE - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] psc_q, psc_d;
    logic          tick_q, tick_d;
    logic          clr_q, clr_d;
    logic          set_q, set_d;
    logic [CW-1:0] init_q, init_d;
    logic          blank_q, blank_d;

    logic          start_prev_q;
    logic          stop_prev_q;
    logic          load_prev_q;

    logic          start_ev;
    logic          stop_ev;
    logic          load_ev;
    logic          load_go;
    logic          start_go;
    logic          hit;

    // Rising-edge events; stop beats load beats start in the same cycle.
    assign start_ev = start & ~start_prev_q;
    assign stop_ev  = stop & ~stop_prev_q;
    assign load_ev  = load_req & ~load_prev_q;
    assign load_go  = load_ev & ~stop_ev;
    assign start_go = start_ev & ~stop_ev & ~load_ev;

    // Terminal compare is masked on the first RUN cycle so clr/set can land.
    assign hit = ~blank_q & (count == target);

    // Button history registers for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            load_prev_q  <= 1'b0;
        end else begin
            start_prev_q <= start;
            stop_prev_q  <= stop;
            load_prev_q  <= load_req;
        end
    end

    // Next state, prescaler and strobe decode.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;
        set_d   = 1'b0;
        init_d  = init_q;
        blank_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load_go) begin
                    set_d  = 1'b1;
                    init_d = load_val;
                end else if (start_go) begin
                    state_d = S_RUN;
                    clr_d   = 1'b1;
                    psc_d   = RELOAD;
                    blank_d = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_ev) begin
                    state_d = S_PAUSE;
                end else if (hit) begin
                    state_d = S_DONE;
                end else if (psc_q == '0) begin
                    tick_d = 1'b1;
                    psc_d  = RELOAD;
                end else begin
                    psc_d = psc_q - PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop_ev) begin
                    state_d = S_IDLE;
                end else if (load_go) begin
                    set_d  = 1'b1;
                    init_d = load_val;
                end else if (start_go) begin
                    state_d = S_RUN;
                    blank_d = 1'b1;
                end
            end
            S_DONE: begin
`ifdef COUNTER_SEQ_AUTO_RELOAD_EN
                if (stop_ev) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                    clr_d   = 1'b1;
                    psc_d   = RELOAD;
                    blank_d = 1'b1;
                end
`else
                if (stop_ev) begin
                    state_d = S_IDLE;
                end else if (start_go) begin
                    state_d = S_RUN;
                    clr_d   = 1'b1;
                    psc_d   = RELOAD;
                    blank_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, prescaler and registered strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            psc_q   <= RELOAD;
            tick_q  <= 1'b0;
            clr_q   <= 1'b0;
            set_q   <= 1'b0;
            init_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
            clr_q   <= clr_d;
            set_q   <= set_d;
            init_q  <= init_d;
            blank_q <= blank_d;
        end
    end

    assign tick  = tick_q;
    assign clr   = clr_q;
    assign set   = set_q;
    assign init  = init_q;
    assign state = state_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);

endmodule
